// File: rtl/mips32_pipelined.sv
// Five-stage MIPS32 subset pipeline (IF/ID/EX/MEM/WB) with operand forwarding,
// a one-bubble load-use interlock, EX-resolved branches and a HLT that drains the pipe.
module mips32_pipelined (
  input  logic clk,
  input  logic rst,
  output logic halted
);
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  logic [31:0] Reg      [0:31];
  logic [31:0] Inst_Mem [0:255];
  logic [31:0] Data_Mem [0:255];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  logic        halt_pending;

  logic        if_id_valid;
  logic [31:0] if_id_ir, if_id_npc;

  logic        ex_valid, ex_wr;
  logic [5:0]  ex_op;
  logic [4:0]  ex_rs, ex_rt, ex_dst;
  logic [31:0] ex_a, ex_b, ex_imm, ex_npc;

  logic        mem_valid, mem_wr;
  logic [5:0]  mem_op;
  logic [4:0]  mem_dst;
  logic [31:0] mem_alu, mem_sd;

  logic        wb_wr, wb_hlt;
  logic [4:0]  wb_dst;
  logic [31:0] wb_val;

  // decode
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd, id_dst;
  logic [31:0] id_imm, id_a, id_b;
  logic        id_rr, id_rm, id_lw, id_sw, id_br, id_hlt;
  logic        id_use_rs, id_use_rt, id_wr;
  logic        load_stall, fetch_stop;

  assign id_op  = if_id_ir[31:26];
  assign id_rs  = if_id_ir[25:21];
  assign id_rt  = if_id_ir[20:16];
  assign id_rd  = if_id_ir[15:11];
  assign id_imm = {{16{if_id_ir[15]}}, if_id_ir[15:0]};

  assign id_rr  = (id_op <= OP_MUL);
  assign id_rm  = (id_op == OP_ADDI) || (id_op == OP_SUBI) || (id_op == OP_SLTI);
  assign id_lw  = (id_op == OP_LW);
  assign id_sw  = (id_op == OP_SW);
  assign id_br  = (id_op == OP_BNEQZ) || (id_op == OP_BEQZ);
  assign id_hlt = if_id_valid && (id_op == OP_HLT);

  assign id_use_rs = if_id_valid && (id_rr || id_rm || id_lw || id_sw || id_br);
  assign id_use_rt = if_id_valid && (id_rr || id_sw);
  assign id_wr     = if_id_valid && (id_rr || id_rm || id_lw);
  assign id_dst    = id_rr ? id_rd : id_rt;

  // WB writes land in the same cycle an ID read of that register happens
  assign id_a = (id_rs == 5'd0) ? 32'd0 :
                (wb_wr && wb_dst == id_rs) ? wb_val : Reg[id_rs];
  assign id_b = (id_rt == 5'd0) ? 32'd0 :
                (wb_wr && wb_dst == id_rt) ? wb_val : Reg[id_rt];

  assign load_stall = ex_valid && (ex_op == OP_LW) && (ex_dst != 5'd0) &&
                      ((id_use_rs && id_rs == ex_dst) || (id_use_rt && id_rt == ex_dst));
  assign fetch_stop = id_hlt || halt_pending;

  // execute, EX/MEM takes priority over MEM/WB as the younger producer
  logic [31:0] fwd_a, fwd_b, ex_alu, br_target;
  logic        br_taken;

  always_comb begin
    fwd_a = ex_a;
    if (ex_rs != 5'd0 && wb_wr && wb_dst == ex_rs) fwd_a = wb_val;
    if (ex_rs != 5'd0 && mem_wr && mem_op != OP_LW && mem_dst == ex_rs) fwd_a = mem_alu;
    fwd_b = ex_b;
    if (ex_rt != 5'd0 && wb_wr && wb_dst == ex_rt) fwd_b = wb_val;
    if (ex_rt != 5'd0 && mem_wr && mem_op != OP_LW && mem_dst == ex_rt) fwd_b = mem_alu;
  end

  always_comb begin
    ex_alu = 32'd0;
    case (ex_op)
      OP_ADD:       ex_alu = fwd_a + fwd_b;
      OP_SUB:       ex_alu = fwd_a - fwd_b;
      OP_AND:       ex_alu = fwd_a & fwd_b;
      OP_OR:        ex_alu = fwd_a | fwd_b;
      OP_SLT:       ex_alu = ($signed(fwd_a) < $signed(fwd_b)) ? 32'd1 : 32'd0;
      OP_MUL:       ex_alu = fwd_a * fwd_b;
      OP_ADDI:      ex_alu = fwd_a + ex_imm;
      OP_SUBI:      ex_alu = fwd_a - ex_imm;
      OP_SLTI:      ex_alu = ($signed(fwd_a) < $signed(ex_imm)) ? 32'd1 : 32'd0;
      OP_LW, OP_SW: ex_alu = fwd_a + ex_imm;
      default:      ex_alu = 32'd0;
    endcase
  end

  assign br_taken  = ex_valid && (((ex_op == OP_BNEQZ) && (fwd_a != 32'd0)) ||
                                  ((ex_op == OP_BEQZ)  && (fwd_a == 32'd0)));
  assign br_target = ex_npc + ex_imm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC           <= 32'd0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      halt_pending <= 1'b0;
      if_id_valid  <= 1'b0;
      if_id_ir     <= 32'd0;
      if_id_npc    <= 32'd0;
      ex_valid     <= 1'b0;
      ex_wr        <= 1'b0;
      ex_op        <= 6'd0;
      ex_rs        <= 5'd0;
      ex_rt        <= 5'd0;
      ex_dst       <= 5'd0;
      ex_a         <= 32'd0;
      ex_b         <= 32'd0;
      ex_imm       <= 32'd0;
      ex_npc       <= 32'd0;
      mem_valid    <= 1'b0;
      mem_wr       <= 1'b0;
      mem_op       <= 6'd0;
      mem_dst      <= 5'd0;
      mem_alu      <= 32'd0;
      mem_sd       <= 32'd0;
      wb_wr        <= 1'b0;
      wb_hlt       <= 1'b0;
      wb_dst       <= 5'd0;
      wb_val       <= 32'd0;
    end else begin
      TAKEN_BRANCH <= br_taken;
      if (wb_hlt) HALTED <= 1'b1;
      if (id_hlt && !br_taken) halt_pending <= 1'b1;

      if (!HALTED) begin
        if (br_taken) begin
          PC          <= br_target;
          if_id_valid <= 1'b0;
        end else if (load_stall) begin
          if_id_valid <= if_id_valid;
        end else if (fetch_stop) begin
          if_id_valid <= 1'b0;
        end else begin
          if_id_valid <= 1'b1;
          if_id_ir    <= Inst_Mem[PC[7:0]];
          if_id_npc   <= PC + 32'd1;
          PC          <= PC + 32'd1;
        end
      end

      ex_valid <= if_id_valid && !br_taken && !load_stall;
      ex_wr    <= id_wr && !br_taken && !load_stall;
      ex_op    <= id_op;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_dst   <= id_dst;
      ex_a     <= id_a;
      ex_b     <= id_b;
      ex_imm   <= id_imm;
      ex_npc   <= if_id_npc;

      mem_valid <= ex_valid;
      mem_wr    <= ex_wr;
      mem_op    <= ex_op;
      mem_dst   <= ex_dst;
      mem_alu   <= ex_alu;
      mem_sd    <= fwd_b;

      wb_wr  <= mem_wr;
      wb_hlt <= mem_valid && (mem_op == OP_HLT);
      wb_dst <= mem_dst;
      wb_val <= (mem_op == OP_LW) ? Data_Mem[mem_alu[7:0]] : mem_alu;
    end
  end

  // architectural storage is never cleared by reset
  always_ff @(posedge clk) begin
    if (!HALTED && wb_wr && wb_dst != 5'd0) Reg[wb_dst] <= wb_val;
    if (!HALTED && mem_valid && mem_op == OP_SW) Data_Mem[mem_alu[7:0]] <= mem_sd;
  end

  assign halted = HALTED;
endmodule

// File: tb/tb_mips32_pipelined.sv
// Directed-program bench: an instruction-level reference model predicts final state
// and the cycle HALTED rises; a per-cycle process compares halted against it.
module tb_mips32_pipelined;
  localparam logic [5:0] ADD = 6'd0, SUB = 6'd1, AND_ = 6'd2, OR_ = 6'd3, SLT = 6'd4, MUL = 6'd5;
  localparam logic [5:0] LW = 6'b001000, SW = 6'b001001, ADDI = 6'b001010, SUBI = 6'b001011;
  localparam logic [5:0] SLTI = 6'b001100, BNEQZ = 6'b001101, BEQZ = 6'b001110, HLT = 6'b111111;
  localparam logic [31:0] HLT_W = 32'hfc000000;
  localparam logic [31:0] FILL  = {6'b001010, 5'd31, 5'd31, 16'd1};

  logic clk, rst, halted;

  mips32_pipelined dut (.clk(clk), .rst(rst), .halted(halted));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] prog     [0:255];
  logic [31:0] init_dm  [0:255];
  logic [31:0] init_reg [0:31];
  logic [31:0] m_dm     [0:255];
  logic [31:0] m_reg    [0:31];
  logic [31:0] m_hlt_pc;
  int m_halt_e;
  int n_checks = 0, n_pass = 0;
  int edge_cnt = 0, first_halt = -1;
  bit run_active = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic bit uses_reg(input logic [31:0] ir, input logic [4:0] r);
    logic [5:0] op;
    bit is_rr, is_rs_user;
    op = ir[31:26];
    is_rr = (op <= MUL);
    is_rs_user = is_rr || op inside {ADDI, SUBI, SLTI, LW, SW, BNEQZ, BEQZ};
    return (is_rs_user && ir[25:21] == r) || ((is_rr || op == SW) && ir[20:16] == r);
  endfunction

  // Instruction-at-a-time execution; e is the cycle each instruction enters EX's
  // input latch, advanced by 1 normally, 3 after a taken branch, 2 across a load-use pair.
  task automatic model_run();
    logic [31:0] pc, ir, a, b, imm, ea, nxt;
    logic [5:0] op;
    logic [4:0] rt, rd;
    int e, step;
    for (int i = 0; i < 32; i++) m_reg[i] = init_reg[i];
    for (int i = 0; i < 256; i++) m_dm[i] = init_dm[i];
    m_reg[0] = 32'd0;
    pc = 32'd0; e = 2; m_halt_e = -1; m_hlt_pc = 32'd0;
    for (int s = 0; s < 4000; s++) begin
      ir = prog[pc[7:0]];
      op = ir[31:26]; rt = ir[20:16]; rd = ir[15:11];
      a = m_reg[ir[25:21]]; b = m_reg[rt];
      imm = {{16{ir[15]}}, ir[15:0]};
      if (op == HLT) begin
        m_halt_e = e + 3;
        m_hlt_pc = pc + 32'd1;
        break;
      end
      nxt = pc + 32'd1; step = 1;
      case (op)
        ADD:   m_reg[rd] = a + b;
        SUB:   m_reg[rd] = a - b;
        AND_:  m_reg[rd] = a & b;
        OR_:   m_reg[rd] = a | b;
        SLT:   m_reg[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        MUL:   m_reg[rd] = a * b;
        ADDI:  m_reg[rt] = a + imm;
        SUBI:  m_reg[rt] = a - imm;
        SLTI:  m_reg[rt] = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        LW: begin
          ea = a + imm;
          m_reg[rt] = m_dm[ea[7:0]];
          if (rt != 5'd0 && uses_reg(prog[nxt[7:0]], rt)) step = 2;
        end
        SW: begin
          ea = a + imm;
          m_dm[ea[7:0]] = b;
        end
        BNEQZ: if (a != 32'd0) begin nxt = pc + 32'd1 + imm; step = 3; end
        BEQZ:  if (a == 32'd0) begin nxt = pc + 32'd1 + imm; step = 3; end
        default: ;
      endcase
      m_reg[0] = 32'd0;
      pc = nxt;
      e += step;
    end
  endtask

  always @(posedge clk) if (run_active) edge_cnt = edge_cnt + 1;

  always @(negedge clk) begin
    if (run_active) begin
      check("halted_per_cycle", {31'd0, halted}, {31'd0, (edge_cnt >= m_halt_e)});
      if (halted && first_halt < 0) first_halt = edge_cnt;
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin prog[i] = FILL; init_dm[i] = 32'd0; end
    for (int i = 0; i < 32; i++) init_reg[i] = 32'd0;
  endtask

  task automatic load_and_model();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 256; i++) begin
      dut.Inst_Mem[i] <= prog[i];
      dut.Data_Mem[i] <= init_dm[i];
    end
    for (int i = 0; i < 32; i++) dut.Reg[i] <= init_reg[i];
    #1;
    model_run();
    if (m_halt_e < 0) begin
      check("model_reaches_hlt", 32'd0, 32'd1);
      m_halt_e = 60;
    end
  endtask

  task automatic start_run();
    @(negedge clk);
    rst = 1'b0;
    edge_cnt = 0;
    first_halt = -1;
    run_active = 1'b1;
  endtask

  task automatic finish_run();
    while (edge_cnt < m_halt_e + 3) @(negedge clk);
    run_active = 1'b0;
    for (int i = 0; i < 32; i++) check($sformatf("R%0d", i), dut.Reg[i], m_reg[i]);
    for (int i = 0; i < 256; i++) check($sformatf("DM%0d", i), dut.Data_Mem[i], m_dm[i]);
    check("pc_frozen", dut.PC, m_hlt_pc);
    check("halted_final", {31'd0, halted}, 32'd1);
    check("halt_edge", first_halt, m_halt_e);
  endtask

  initial begin
    rst = 1'b1;
    #12;
    check("reset_pc", dut.PC, 32'd0);
    check("reset_halted", {31'd0, halted}, 32'd0);

    // load followed by dependent ops, separated by dummy ORs
    clear_prog();
    prog[0] = 32'h28010078; prog[1] = 32'h0c631800; prog[2] = 32'h20220000;
    prog[3] = 32'h0c631800; prog[4] = 32'h2842002d; prog[5] = 32'h0c631800;
    prog[6] = 32'h24220001; prog[7] = 32'hfc000000;
    init_dm[120] = 32'd85;
    load_and_model();
    start_run();
    finish_run();
    check("p1_r1", dut.Reg[1], 32'd120);
    check("p1_r2", dut.Reg[2], 32'd130);
    check("p1_dm121", dut.Data_Mem[121], 32'h82);
    check("p1_within_15", {31'd0, (first_halt >= 0 && first_halt <= 15)}, 32'd1);

    // same program with no spacers: forwarding plus one load-use bubble
    clear_prog();
    prog[0] = 32'h28010078; prog[1] = 32'h20220000; prog[2] = 32'h2842002d;
    prog[3] = 32'h24220001; prog[4] = 32'hfc000000;
    init_dm[120] = 32'd85;
    load_and_model();
    start_run();
    finish_run();
    check("p2_r2", dut.Reg[2], 32'd130);
    check("p2_dm121", dut.Data_Mem[121], 32'h82);
    check("p2_halt_edge", first_halt, 32'd10);

    // ALU mix, with an asynchronous reset after the third commit
    clear_prog();
    prog[0] = ri(ADDI, 1, 0, 7);  prog[1] = ri(ADDI, 2, 0, -3);
    prog[2] = rr(ADD, 3, 1, 2);   prog[3] = rr(SUB, 4, 2, 1);
    prog[4] = rr(MUL, 5, 1, 2);   prog[5] = rr(SLT, 6, 2, 1);
    prog[6] = rr(AND_, 7, 1, 2);  prog[7] = HLT_W;
    load_and_model();
    start_run();
    repeat (7) @(posedge clk);
    run_active = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("midrst_pc", dut.PC, 32'd0);
    check("midrst_halted", {31'd0, halted}, 32'd0);
    check("midrst_r3_kept", dut.Reg[3], 32'd4);
    check("midrst_r4_untouched", dut.Reg[4], 32'd0);
    repeat (2) @(negedge clk);
    check("midrst_r4_after", dut.Reg[4], 32'd0);
    check("midrst_r1_kept", dut.Reg[1], 32'd7);
    start_run();
    finish_run();
    check("p3_r3", dut.Reg[3], 32'd4);
    check("p3_r4", dut.Reg[4], 32'hFFFFFFF6);
    check("p3_r5", dut.Reg[5], 32'hFFFFFFEB);
    check("p3_r6", dut.Reg[6], 32'd1);
    check("p3_r7", dut.Reg[7], 32'd5);

    // factorial loop
    clear_prog();
    prog[0] = ri(ADDI, 2, 0, 1);  prog[1] = ri(ADDI, 3, 0, 5);
    prog[2] = rr(MUL, 2, 2, 3);   prog[3] = ri(SUBI, 3, 3, 1);
    prog[4] = ri(BNEQZ, 0, 3, -3); prog[5] = ri(SW, 2, 0, 0);
    prog[6] = HLT_W;
    load_and_model();
    start_run();
    finish_run();
    check("fact_dm0", dut.Data_Mem[0], 32'd120);
    check("fact_r3", dut.Reg[3], 32'd0);

    // taken branch squashing a HLT, not-taken branch, NOP opcode, load-use on store data
    clear_prog();
    prog[0]  = ri(ADDI, 1, 0, 3);   prog[1]  = ri(BEQZ, 0, 0, 2);
    prog[2]  = HLT_W;               prog[3]  = ri(ADDI, 1, 0, 99);
    prog[4]  = ri(ADDI, 2, 1, 1);   prog[5]  = rr(OR_, 3, 1, 2);
    prog[6]  = ri(SLTI, 4, 2, 5);   prog[7]  = ri(SUBI, 5, 3, 10);
    prog[8]  = ri(BNEQZ, 0, 0, 5);  prog[9]  = rr(6'b010101, 9, 1, 2);
    prog[10] = ri(SW, 5, 1, 3);     prog[11] = ri(LW, 6, 1, 3);
    prog[12] = ri(SW, 6, 0, 7);     prog[13] = HLT_W;
    load_and_model();
    start_run();
    finish_run();
    check("br_r1", dut.Reg[1], 32'd3);
    check("br_r3", dut.Reg[3], 32'd7);
    check("br_r4", dut.Reg[4], 32'd1);
    check("br_r5", dut.Reg[5], 32'hFFFFFFFD);
    check("br_dm7", dut.Data_Mem[7], 32'hFFFFFFFD);
    check("br_halt_edge", first_halt, 32'd19);

    // R0 writes discarded; youngest producer wins
    clear_prog();
    init_reg[1] = 32'h0000DEAD;
    prog[0] = ri(ADDI, 0, 0, 5);  prog[1] = rr(ADD, 1, 0, 0);
    prog[2] = ri(ADDI, 8, 0, 1);  prog[3] = ri(ADDI, 8, 8, 2);
    prog[4] = rr(ADD, 9, 8, 8);   prog[5] = HLT_W;
    load_and_model();
    start_run();
    finish_run();
    check("r0_r1", dut.Reg[1], 32'd0);
    check("r0_r0", dut.Reg[0], 32'd0);
    check("fwd_r9", dut.Reg[9], 32'd6);

    #2 rst = 1'b1;
    #1;
    check("rst_after_halt", {31'd0, halted}, 32'd0);
    check("rst_after_halt_pc", dut.PC, 32'd0);
    check("rst_keeps_reg", dut.Reg[9], 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mips32_pipelined.md
MIPS32_PIPELINED -- requirements
Module: mips32_pipelined

Interface
REQ-001 clk  input  1  sole clock; every state element updates on the rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 halted  output  1  mirrors internal HALTED flag.
REQ-004 Internal state SHALL be held in these hierarchically accessible registers: Reg[0:31] (32b), Inst_Mem[0:255] (32b), Data_Mem[0:255] (32b), PC (32b), HALTED (1b), TAKEN_BRANCH (1b).

Function
REQ-005 Datapath SHALL be a 5-stage pipeline: IF, ID, EX, MEM, WB, with one instruction per stage per cycle.
REQ-006 Instruction format SHALL be opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0], with imm sign-extended to 32 bits.
REQ-007 RR ops (rd <= rs op rt) SHALL be: 000000 ADD, 000001 SUB, 000010 AND, 000011 OR, 000100 SLT (signed, result 1/0), 000101 MUL (low 32 bits).
REQ-008 RM ops (rt <= rs op imm) SHALL be: 001010 ADDI, 001011 SUBI, 001100 SLTI (signed).
REQ-009 Memory ops SHALL be: 001000 LW (rt <= Data_Mem[(rs+imm)[7:0]]) and 001001 SW (Data_Mem[(rs+imm)[7:0]] <= rt).
REQ-010 Branch ops SHALL be: 001101 BNEQZ (taken if rs!=0) and 001110 BEQZ (taken if rs==0); target = branch PC + 1 + imm (word addressing).
REQ-011 Opcode 111111 SHALL be HLT; every other opcode SHALL execute as a NOP.
REQ-012 Arithmetic SHALL wrap modulo 2^32 with no overflow trap.
REQ-013 Fetch SHALL read Inst_Mem[PC[7:0]], and PC SHALL increment by 1 per fetch.
REQ-014 Reg[0] SHALL read as 0, and writes to it SHALL be discarded.
REQ-015 Register-file writes in WB SHALL be visible to a same-cycle ID read (write-before-read bypass).
REQ-016 EX operands SHALL be forwarded from EX/MEM (ALU result) and MEM/WB (ALU or load data); the youngest producer wins, and R0 is never forwarded.
REQ-017 SW store data SHALL be forwarded by the same rules as REQ-016.
REQ-018 A load followed immediately by a consumer of its rt SHALL stall IF/ID for exactly one cycle and insert one bubble into EX.
REQ-019 Branches SHALL resolve in EX, using forwarded rs.
REQ-020 On a taken branch, PC SHALL load the target on the next edge, the two younger instructions in IF/ID and ID/EX SHALL become bubbles, and TAKEN_BRANCH SHALL be set to 1 for that cycle.
REQ-021 Taken-branch penalty SHALL be 2 cycles; a not-taken branch SHALL have 0 penalty.
REQ-022 When HLT is in ID, IF SHALL stop advancing PC and SHALL inject bubbles.
REQ-023 When HLT reaches WB, HALTED SHALL become 1 on that edge.
REQ-024 When HALTED=1, PC, Reg and Data_Mem SHALL freeze until reset.
REQ-025 A HLT squashed by a taken branch SHALL have no effect, and fetch SHALL resume at the branch target.
REQ-026 Instructions after HLT SHALL never write Reg or Data_Mem.
REQ-027 Latency from fetch to register write SHALL be 5 cycles; throughput SHALL be 1 instruction per cycle absent stalls and flushes.

Reset
REQ-028 rst=1 SHALL asynchronously set PC=0, HALTED=0, halted=0 and TAKEN_BRANCH=0, and SHALL set all pipeline registers to bubbles.
REQ-029 Reset SHALL NOT alter Reg, Inst_Mem or Data_Mem.
REQ-030 After rst deasserts, the first fetch SHALL occur at the first rising clk edge and SHALL read Inst_Mem[0].
REQ-031 Reset asserted mid-program SHALL abort all in-flight instructions with no further Reg or Data_Mem writes.

Verification
REQ-032 Program 28010078, 0c631800, 20220000, 0c631800, 2842002d, 0c631800, 24220001, fc000000 with Data_Mem[120]=85 -> R1=120, R2=130, Data_Mem[121]=0x82, halted=1 within 15 cycles.
REQ-033 The same program with all dummy ORs removed -> identical results via forwarding plus one load-use stall.
REQ-034 ADDI R1,R0,7; ADDI R2,R0,-3; ADD R3,R1,R2; SUB R4,R2,R1; MUL R5,R1,R2; SLT R6,R2,R1; AND R7,R1,R2; HLT -> R3=4, R4=0xFFFFFFF6, R5=0xFFFFFFEB, R6=1, R7=5.
REQ-035 Factorial loop (R2=1, R3=5; MUL R2,R2,R3; SUBI R3,R3,1; BNEQZ R3,-3; SW R2,0(R0); HLT) -> Data_Mem[0]=120, and the instructions after BNEQZ never commit while the branch is taken.
REQ-036 Write to R0 (ADDI R0,R0,5), then ADD R1,R0,R0 -> R1=0.
REQ-037 rst pulsed while a program is mid-execution -> PC=0 and halted=0 immediately, Reg unchanged, and the program re-executes from Inst_Mem[0].
